// File: rtl/note_player.sv
// Single-voice tone generator: a recognised key press starts a square-wave note
// that runs until the key is released, the hold limit expires, or another key is pressed.
module note_player #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int MAX_HOLD = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key_code,
    input  logic       key_valid,
    input  logic       key_released,
    input  logic       mute,
    output logic       buzzer,
    output logic [2:0] note,
    output logic       playing,
    output logic [7:0] note_count
);

    // Half-period divisors in clock cycles, truncated at elaboration.
    localparam int DIV1 = CLK_HZ / (2 * 262);
    localparam int DIV2 = CLK_HZ / (2 * 294);
    localparam int DIV3 = CLK_HZ / (2 * 330);
    localparam int DIV4 = CLK_HZ / (2 * 349);
    localparam int DIV5 = CLK_HZ / (2 * 392);
    localparam int DIV6 = CLK_HZ / (2 * 440);
    localparam int DIV7 = CLK_HZ / (2 * 494);

    // The lowest note has the largest divisor, so it sizes the tone counter.
    localparam int TONE_W = (DIV1 > 1) ? $clog2(DIV1) : 1;
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PLAY = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [2:0]          note_nxt;
    logic [7:0]          count_nxt;
    logic [TONE_W-1:0]   tone_cnt, tone_cnt_nxt;
    logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nxt;
    logic                tone, tone_nxt;
    logic                buzzer_nxt;

    logic [2:0]          press_note;
    logic                accept;
    logic [TONE_W-1:0]   div_m1;
    logic                tone_wrap;
    logic                hold_done;

    always_comb begin
        case (key_code)
            8'h1A:   press_note = 3'd1;
            8'h22:   press_note = 3'd2;
            8'h21:   press_note = 3'd3;
            8'h2A:   press_note = 3'd4;
            8'h32:   press_note = 3'd5;
            8'h31:   press_note = 3'd6;
            8'h3A:   press_note = 3'd7;
            default: press_note = 3'd0;
        endcase
    end

    assign accept = key_valid && (press_note != 3'd0);

    // Wrap point of the tone counter for the note currently sounding.
    always_comb begin
        case (note)
            3'd1:    div_m1 = TONE_W'(DIV1 - 1);
            3'd2:    div_m1 = TONE_W'(DIV2 - 1);
            3'd3:    div_m1 = TONE_W'(DIV3 - 1);
            3'd4:    div_m1 = TONE_W'(DIV4 - 1);
            3'd5:    div_m1 = TONE_W'(DIV5 - 1);
            3'd6:    div_m1 = TONE_W'(DIV6 - 1);
            3'd7:    div_m1 = TONE_W'(DIV7 - 1);
            default: div_m1 = '0;
        endcase
    end

    assign tone_wrap = (tone_cnt == div_m1);
    assign hold_done = (hold_cnt == HOLD_W'(MAX_HOLD - 1));

    always_comb begin
        // NOTE: every next-state variable gets a default first so no path leaves one unassigned (no latches).
        state_nxt    = state;
        note_nxt     = note;
        count_nxt    = note_count;
        tone_cnt_nxt = tone_cnt;
        hold_cnt_nxt = hold_cnt;
        tone_nxt     = tone;

        if (accept) begin
            // A new press wins over release and timeout, and restarts the tone phase.
            state_nxt    = S_PLAY;
            note_nxt     = press_note;
            count_nxt    = note_count + 8'd1;
            tone_cnt_nxt = '0;
            hold_cnt_nxt = '0;
            tone_nxt     = 1'b0;
        end else if (state == S_PLAY) begin
            if (key_released || hold_done) begin
                state_nxt    = S_IDLE;
                note_nxt     = 3'd0;
                tone_cnt_nxt = '0;
                hold_cnt_nxt = '0;
                tone_nxt     = 1'b0;
            end else begin
                tone_cnt_nxt = tone_wrap ? '0 : tone_cnt + TONE_W'(1);
                tone_nxt     = tone_wrap ? ~tone : tone;
                hold_cnt_nxt = hold_cnt + HOLD_W'(1);
            end
        end

        // Mute gates only the pin; the tone keeps running underneath.
        buzzer_nxt = tone_nxt & ~mute;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            state      <= S_IDLE;
            note       <= 3'd0;
            note_count <= 8'd0;
            tone_cnt   <= '0;
            hold_cnt   <= '0;
            tone       <= 1'b0;
            buzzer     <= 1'b0;
        end else begin
            state      <= state_nxt;
            note       <= note_nxt;
            note_count <= count_nxt;
            tone_cnt   <= tone_cnt_nxt;
            hold_cnt   <= hold_cnt_nxt;
            tone       <= tone_nxt;
            buzzer     <= buzzer_nxt;
        end
    end

    assign playing = (state == S_PLAY);

endmodule
